fetch_unit: RTL and testbench
=============================

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter INSTRUCTION, default 32, SHALL be the instruction word width.
REQ-002 Parameter ADDRESS, default 32, SHALL be the program-counter width.
REQ-003 Parameter RESET_PC, default 32'h0000_0000, SHALL be the first fetch address after reset.
REQ-004 clk  input  1  SHALL be the single clock; all state updates on rising edge.
REQ-005 reset  input  1  SHALL be the reset, asynchronous and active-high.
REQ-006 imem_req_valid  output  1  SHALL flag a fetch request.
REQ-007 imem_req_ready  input  1  SHALL flag that memory accepts the request.
REQ-008 imem_req_addr  output  ADDRESS  SHALL be the fetch address.
REQ-009 imem_rsp_valid  input  1  SHALL flag returned instruction data.
REQ-010 imem_rsp_data  input  INSTRUCTION  SHALL be the returned instruction word.
REQ-011 redirect_valid  input  1  SHALL flag a control-flow change (taken branch).
REQ-012 redirect_pc  input  ADDRESS  SHALL be the redirect target.
REQ-013 instr_valid  output  1  SHALL flag an instruction for decode/immediate generation.
REQ-014 instr_ready  input  1  SHALL flag that decode consumes the instruction.
REQ-015 instruction  output  INSTRUCTION  SHALL be the fetched word.
REQ-016 instr_pc  output  ADDRESS  SHALL be the address of the fetched word.

Function
REQ-017 FSM states SHALL be IDLE, REQ, WAIT, DROP, HOLD; at most one request outstanding.
REQ-018 imem_req_valid SHALL be 1 only in REQ; imem_req_addr SHALL equal pc.
REQ-019 IDLE SHALL go to REQ unconditionally on the next edge.
REQ-020 REQ: req_ready=1 and no redirect -> WAIT; req_ready=0 -> stay REQ, pc and addr held stable.
REQ-021 WAIT: rsp_valid=1 -> latch instruction=rsp_data, instr_pc=pc, pc<=pc+4, go HOLD (rsp-to-instr_valid latency 1 cycle).
REQ-022 HOLD: instr_valid SHALL be 1 and instruction/instr_pc held stable; instr_ready=1 -> REQ.
REQ-023 Redirect in REQ: pc<=redirect_pc; if req_ready=1 same cycle -> DROP, else stay REQ.
REQ-024 Redirect in WAIT: pc<=redirect_pc; if rsp_valid=1 same cycle -> discard data, go REQ; else -> DROP.
REQ-025 DROP: rsp_valid=1 -> discard data, go REQ; redirect in DROP updates pc, stays DROP.
REQ-026 Redirect in HOLD SHALL take priority over instr_ready: instr_valid forced 0 combinationally that cycle, pc<=redirect_pc, go REQ.
REQ-027 Redirect in IDLE: pc<=redirect_pc, go REQ.
REQ-028 pc<=redirect_pc SHALL force bits [1:0] to 0.
REQ-029 pc+4 SHALL wrap modulo 2^ADDRESS (32'hFFFF_FFFC -> 32'h0000_0000).
REQ-030 Discarded responses SHALL never reach instr_valid.

Reset
REQ-031 Reset SHALL force state=IDLE, pc=RESET_PC, instruction=0, instr_pc=0, imem_req_valid=0, instr_valid=0, immediately and asynchronously.
REQ-032 Reset asserted mid-WAIT SHALL abandon the outstanding request; a response arriving after reset release before the first new request SHALL be ignored (state IDLE/REQ ignores rsp_valid).

Verification
REQ-033 Release reset, req_ready=1, rsp 1 cycle later with 32'h00A00093 -> addr 0x0 in cycle 1, instr_valid with instruction=32'h00A00093, instr_pc=0x0; next addr 0x4.
REQ-034 req_ready low 3 cycles -> imem_req_valid and addr 0x0 stable all 3 cycles; accepted on 4th.
REQ-035 instr_ready low 5 cycles in HOLD -> instruction/instr_pc stable, no new request issued.
REQ-036 Redirect to 0x103 while WAIT, rsp arrives 2 cycles later -> response dropped, next request addr 0x100, no instr_valid for old data.
REQ-037 Redirect and instr_ready both 1 in HOLD -> instr_valid 0 that cycle, next addr = redirect_pc; pc 0xFFFF_FFFC fetch -> next addr 0x0.
REQ-038 Assert reset in WAIT -> outputs 0 immediately; after release first addr = RESET_PC.

Source files
------------

// File: rtl/fetch_unit.sv
// Instruction fetch stage: issues one memory request at a time and holds
// each fetched word until decode takes it; redirects squash in-flight work.
module fetch_unit #(
  parameter int INSTRUCTION = 32,
  parameter int ADDRESS = 32,
  parameter logic [ADDRESS-1:0] RESET_PC = '0
) (
  input  logic                   clk,
  input  logic                   reset,
  output logic                   imem_req_valid,
  input  logic                   imem_req_ready,
  output logic [ADDRESS-1:0]     imem_req_addr,
  input  logic                   imem_rsp_valid,
  input  logic [INSTRUCTION-1:0] imem_rsp_data,
  input  logic                   redirect_valid,
  input  logic [ADDRESS-1:0]     redirect_pc,
  output logic                   instr_valid,
  input  logic                   instr_ready,
  output logic [INSTRUCTION-1:0] instruction,
  output logic [ADDRESS-1:0]     instr_pc
);

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    WAIT,
    DROP,
    HOLD
  } state_t;

  state_t state, state_nx;

  logic [ADDRESS-1:0]     pc, pc_nx;
  logic [ADDRESS-1:0]     target;
  logic [INSTRUCTION-1:0] instr_nx;
  logic [ADDRESS-1:0]     ipc_nx;

  assign target = {redirect_pc[ADDRESS-1:2], 2'b00};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      pc          <= RESET_PC;
      instruction <= '0;
      instr_pc    <= '0;
    end else begin
      state       <= state_nx;
      pc          <= pc_nx;
      instruction <= instr_nx;
      instr_pc    <= ipc_nx;
    end
  end

  always_comb begin
    state_nx = state;
    pc_nx    = pc;
    instr_nx = instruction;
    ipc_nx   = instr_pc;
    unique case (state)
      IDLE: begin
        if (redirect_valid) pc_nx = target;
        state_nx = REQ;
      end
      REQ: begin
        if (redirect_valid) begin
          pc_nx = target;
          // an accepted stale request must still be drained
          if (imem_req_ready) state_nx = DROP;
        end else if (imem_req_ready) begin
          state_nx = WAIT;
        end
      end
      WAIT: begin
        if (redirect_valid) begin
          pc_nx    = target;
          state_nx = imem_rsp_valid ? REQ : DROP;
        end else if (imem_rsp_valid) begin
          instr_nx = imem_rsp_data;
          ipc_nx   = pc;
          pc_nx    = pc + ADDRESS'(4);
          state_nx = HOLD;
        end
      end
      DROP: begin
        if (redirect_valid) pc_nx = target;
        if (imem_rsp_valid) state_nx = REQ;
      end
      HOLD: begin
        if (redirect_valid) begin
          pc_nx    = target;
          state_nx = REQ;
        end else if (instr_ready) begin
          state_nx = REQ;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  assign imem_req_valid = (state == REQ);
  assign imem_req_addr  = pc;
  assign instr_valid    = (state == HOLD) && !redirect_valid;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: a latency-randomised memory plus a flow-level
// model of which fetched words decode should see, and in what order.
module tb_fetch_unit;

  localparam logic [31:0] RPC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b0;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data = '0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        instr_valid;
  logic        instr_ready = 1'b0;
  logic [31:0] instruction;
  logic [31:0] instr_pc;

  fetch_unit #(
    .INSTRUCTION(32),
    .ADDRESS(32),
    .RESET_PC(RPC)
  ) dut (
    .clk(clk),
    .reset(reset),
    .imem_req_valid(imem_req_valid),
    .imem_req_ready(imem_req_ready),
    .imem_req_addr(imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid),
    .imem_rsp_data(imem_rsp_data),
    .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc),
    .instr_valid(instr_valid),
    .instr_ready(instr_ready),
    .instruction(instruction),
    .instr_pc(instr_pc)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] data;
  } item_t;

  // words decode is owed, in program order
  item_t       q[$];
  logic [31:0] exp_pc = RPC;
  bit          idle = 1'b1;

  // single-slot memory
  bit          pend = 1'b0;
  bit          pend_stale = 1'b0;
  logic [31:0] pend_addr = '0;
  logic [31:0] pend_data = '0;
  int          pend_cnt = 0;
  int          lat = 0;
  bit          fix_en = 1'b0;
  logic [31:0] fix_data = '0;

  task automatic mem_drive();
    if (pend && pend_cnt == 0) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = pend_data;
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = $urandom;
      if (pend) pend_cnt--;
    end
  endtask

  task automatic cycle();
    bit          acc, rsp, red, con;
    logic [31:0] addr, tgt;
    @(negedge clk);
    check("instr_valid", instr_valid, (q.size() > 0 && !redirect_valid));
    if (q.size() > 0 && instr_valid) begin
      check("instruction", instruction, q[0].data);
      check("instr_pc", instr_pc, q[0].pc);
    end
    check("req_valid", imem_req_valid, (!idle && !pend && q.size() == 0));
    if (imem_req_valid) check("req_addr", imem_req_addr, exp_pc);
    acc  = imem_req_valid && imem_req_ready;
    rsp  = imem_rsp_valid;
    red  = redirect_valid;
    con  = instr_valid && instr_ready;
    addr = imem_req_addr;
    tgt  = redirect_pc;
    @(posedge clk);
    if (con && q.size() > 0) void'(q.pop_front());
    if (rsp && pend) begin
      if (!pend_stale && !red) begin
        q.push_back('{pend_addr, pend_data});
        exp_pc = pend_addr + 32'd4;
      end
      pend = 1'b0;
    end
    if (acc) begin
      pend       = 1'b1;
      pend_stale = red;
      pend_addr  = addr;
      pend_data  = fix_en ? fix_data : $urandom;
      pend_cnt   = (lat > 0 ? lat : int'($urandom_range(1, 3))) - 1;
    end
    if (red) begin
      q.delete();
      pend_stale = 1'b1;
      exp_pc     = {tgt[31:2], 2'b00};
    end
    idle = 1'b0;
    #1 mem_drive();
  endtask

  // async reset mid-cycle; an abandoned response shows up right after release
  task automatic do_reset();
    #2 reset = 1'b1;
    #1;
    check("rst_req_valid", imem_req_valid, 0);
    check("rst_instr_valid", instr_valid, 0);
    check("rst_instruction", instruction, 0);
    check("rst_instr_pc", instr_pc, 0);
    check("rst_addr", imem_req_addr, RPC);
    q.delete();
    if (pend) begin
      pend_stale = 1'b1;
      pend_cnt   = 0;
    end
    exp_pc         = RPC;
    idle           = 1'b1;
    imem_rsp_valid = 1'b0;
    redirect_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    mem_drive();
  endtask

  initial begin
    do_reset();

    // first fetch, one-cycle memory
    fix_en = 1'b1;
    fix_data = 32'h00A0_0093;
    lat = 1;
    imem_req_ready = 1'b1;
    cycle();
    #2 check("r33_req", imem_req_valid, 1);
    check("r33_addr", imem_req_addr, 32'h0);
    cycle();
    cycle();
    #2 check("r33_valid", instr_valid, 1);
    check("r33_instr", instruction, 32'h00A0_0093);
    check("r33_pc", instr_pc, 32'h0);
    instr_ready = 1'b1;
    cycle();
    instr_ready = 1'b0;
    fix_en = 1'b0;
    #2 check("r33_next", imem_req_addr, 32'h4);

    // memory back-pressure
    imem_req_ready = 1'b0;
    repeat (3) begin
      #2 check("r34_req", imem_req_valid, 1);
      check("r34_addr", imem_req_addr, 32'h4);
      cycle();
    end
    imem_req_ready = 1'b1;
    cycle();
    cycle();

    // decode back-pressure
    repeat (5) begin
      #2 check("r35_valid", instr_valid, 1);
      check("r35_noreq", imem_req_valid, 0);
      check("r35_pc", instr_pc, 32'h4);
      cycle();
    end
    instr_ready = 1'b1;
    cycle();
    instr_ready = 1'b0;

    // redirect while waiting, late response dropped
    lat = 3;
    cycle();
    redirect_valid = 1'b1;
    redirect_pc = 32'h103;
    cycle();
    redirect_valid = 1'b0;
    cycle();
    #2 check("r36_rsp", imem_rsp_valid, 1);
    check("r36_novalid", instr_valid, 0);
    cycle();
    #2 check("r36_req", imem_req_valid, 1);
    check("r36_addr", imem_req_addr, 32'h100);
    check("r36_novalid2", instr_valid, 0);

    // redirect beats instr_ready; pc wraps
    lat = 1;
    cycle();
    cycle();
    redirect_valid = 1'b1;
    redirect_pc = 32'hFFFF_FFFC;
    instr_ready = 1'b1;
    #2 check("r37_kill", instr_valid, 0);
    cycle();
    redirect_valid = 1'b0;
    instr_ready = 1'b0;
    #2 check("r37_addr", imem_req_addr, 32'hFFFF_FFFC);
    cycle();
    cycle();
    #2 check("r37_pc", instr_pc, 32'hFFFF_FFFC);
    instr_ready = 1'b1;
    cycle();
    instr_ready = 1'b0;
    #2 check("r37_wrap", imem_req_addr, 32'h0);

    // reset with a request outstanding
    cycle();
    do_reset();
    #2 check("r38_idle", imem_req_valid, 0);
    cycle();
    #2 check("r38_addr", imem_req_addr, RPC);
    check("r38_req", imem_req_valid, 1);

    // random traffic
    lat = 0;
    for (int i = 0; i < 4000; i++) begin
      imem_req_ready = ($urandom % 10) < 7;
      instr_ready = ($urandom % 10) < 6;
      redirect_valid = ($urandom % 20) == 0;
      redirect_pc = $urandom;
      if ($urandom % 4 == 0)
        redirect_pc = 32'hFFFF_FFF0 | ($urandom & 32'hF);
      if ($urandom % 500 == 0) do_reset();
      else cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
